// File: rtl/slave_pkg.sv
// Shared definitions for the Slave ALU serial front end: opcode and FSM
// encodings plus the command frame length derived from the operand width.
package slave_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_APPLY,
        ST_WAIT,
        ST_DONE
    } fsm_state_t;

    // N, Z, C, V travel ahead of the result in the response frame
    localparam int FLAG_BITS = 4;

    function automatic int frame_bits(input int width);
        return 2 + 2 * width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser for signals crossing into clk.
// RESET_VAL lets idle-high pins such as chip select come out of reset inactive.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/alu_spi_frontend.sv
// SPI mode-0 slave that turns {opcode, A, B} command frames into registered ALU
// operands and returns the captured {N,Z,C,V,result} on the following frame.
module alu_spi_frontend
    import slave_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    output logic             operands_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             frame_error
);

    localparam int FB        = frame_bits(WIDTH);
    localparam int RESP_BITS = FLAG_BITS + WIDTH;
    localparam int PAD       = FB - RESP_BITS;
    localparam int CNT_W     = $clog2(FB + 1);
    localparam int LAT_W     = $clog2(ALU_LATENCY + 1);

    logic [2:0]           pins_s;
    logic                 sclk_s, cs_s, mosi_s;
    logic                 sclk_d;
    logic                 sclk_rise, sclk_fall;
    fsm_state_t           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [LAT_W-1:0]     lat_cnt;
    logic [FB-1:0]        rx_shift;
    logic [FB-1:0]        tx_shift;
    logic [RESP_BITS-1:0] resp_hold;
    logic [FB-1:0]        resp_ext;
    alu_op_t              op_q;

    // Chip select resets high so the FSM does not see a phantom frame start
    sync_2ff #(
        .WIDTH     (3),
        .RESET_VAL (3'b010)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({sclk, cs_n, mosi}),
        .q   (pins_s)
    );

    assign sclk_s    = pins_s[2];
    assign cs_s      = pins_s[1];
    assign mosi_s    = pins_s[0];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    assign resp_ext   = FB'(resp_hold);
    assign alu_opcode = op_q;
    assign miso       = ((state != ST_IDLE) && !cs_s) ? tx_shift[FB-1] : 1'b0;

    // Captured responses park in resp_hold and only reach tx_shift at the next
    // frame start, so a response already being shifted out is never disturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            sclk_d         <= 1'b0;
            bit_cnt        <= '0;
            lat_cnt        <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            resp_hold      <= '0;
            op_q           <= OP_ADD;
            alu_a          <= '0;
            alu_b          <= '0;
            operands_valid <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            sclk_d         <= sclk_s;
            operands_valid <= 1'b0;
            frame_error    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!cs_s) begin
                        state    <= ST_RECV;
                        bit_cnt  <= '0;
                        tx_shift <= resp_ext << PAD;
                    end
                end
                ST_RECV: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[FB-2:0], mosi_s};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(FB - 1)) begin
                            state <= ST_APPLY;
                        end
                    end else if (cs_s) begin
                        frame_error <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sclk_fall) begin
                        tx_shift <= {tx_shift[FB-2:0], 1'b0};
                    end
                end
                ST_APPLY: begin
                    op_q           <= alu_op_t'(rx_shift[FB-1 -: 2]);
                    alu_a          <= rx_shift[2*WIDTH-1 -: WIDTH];
                    alu_b          <= rx_shift[WIDTH-1:0];
                    operands_valid <= 1'b1;
                    lat_cnt        <= '0;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt == LAT_W'(ALU_LATENCY - 1)) begin
                        resp_hold <= {alu_n, alu_z, alu_c, alu_v, alu_result};
                        state     <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_spi_frontend.sv
// Directed bench for alu_spi_frontend: the bench plays SPI master and provides a
// small combinational ALU, then checks operands, pulses and returned responses.
module tb_alu_spi_frontend;
    import slave_pkg::*;

    localparam int W  = 4;
    localparam int FB = 2 + 2 * W;

    logic         clk;
    logic         rst;
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_opcode;
    logic         operands_valid;
    logic [W-1:0] alu_result;
    logic         alu_n, alu_z, alu_c, alu_v;
    logic         frame_error;
    logic [W:0]   alu_sum;

    int  checks;
    int  fails;
    int  hp;
    int  valid_cnt;
    int  err_cnt;
    time last_rise_t;
    time last_valid_t;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [FB-1:0] resp;
    } vec_t;

    vec_t vecs[6];

    alu_spi_frontend #(
        .WIDTH       (W),
        .ALU_LATENCY (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .cs_n           (cs_n),
        .mosi           (mosi),
        .miso           (miso),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_opcode     (alu_opcode),
        .operands_valid (operands_valid),
        .alu_result     (alu_result),
        .alu_n          (alu_n),
        .alu_z          (alu_z),
        .alu_c          (alu_c),
        .alu_v          (alu_v),
        .frame_error    (frame_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in ALU: N only meaningful for subtract, C is the add carry, V unused
    always_comb begin
        alu_sum = '0;
        case (alu_opcode)
            OP_ADD:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_sum = {1'b0, alu_a & alu_b};
            default: alu_sum = {1'b0, alu_a | alu_b};
        endcase
        alu_result = alu_sum[W-1:0];
        alu_n      = (alu_opcode == OP_SUB) && alu_sum[W-1];
        alu_z      = (alu_sum[W-1:0] == '0);
        alu_c      = (alu_opcode == OP_ADD) && alu_sum[W];
        alu_v      = 1'b0;
    end

    always @(negedge clk) begin
        if (operands_valid) begin
            valid_cnt    = valid_cnt + 1;
            last_valid_t = $time;
        end
        if (frame_error) begin
            err_cnt = err_cnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One master transaction; bits past the command length are sent as ones
    task automatic apply_stimulus(input logic [FB-1:0] cmd, input int nbits,
                                  input bit end_frame, output logic [FB-1:0] rx);
        rx   = '0;
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < FB) ? cmd[FB-1-i] : 1'b1;
            #(hp);
            sclk        = 1'b1;
            last_rise_t = $time;
            #(hp - 1);
            if (i < FB) rx[FB-1-i] = miso;
            #1;
            sclk = 1'b0;
        end
        if (end_frame) begin
            #(hp);
            cs_n = 1'b1;
        end
    endtask

    initial begin
        logic [FB-1:0] rx, rx_a, rx_b;
        logic [FB-1:0] prev_resp;
        logic [W-1:0]  keep_a, keep_b;
        logic [1:0]    keep_op;
        int            v0, e0;

        checks    = 0;
        fails     = 0;
        valid_cnt = 0;
        err_cnt   = 0;
        hp        = 40;
        rst       = 1'b1;
        sclk      = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;

        vecs[0] = '{OP_ADD, 4'd3,     4'd5,     10'b0000_1000_00};
        vecs[1] = '{OP_SUB, 4'b0010,  4'b0101,  10'b1000_1101_00};
        vecs[2] = '{OP_AND, 4'b1010,  4'b0101,  10'b0100_0000_00};
        vecs[3] = '{OP_OR,  4'b1010,  4'b0100,  10'b0000_1110_00};
        vecs[4] = '{OP_ADD, 4'd9,     4'd8,     10'b0010_0001_00};
        vecs[5] = '{OP_SUB, 4'd7,     4'd7,     10'b0100_0000_00};

        repeat (3) @(negedge clk);
        check_output("reset alu_a", 32'(alu_a), 32'd0);
        check_output("reset alu_b", 32'(alu_b), 32'd0);
        check_output("reset alu_opcode", 32'(alu_opcode), 32'd0);
        check_output("reset operands_valid", 32'(operands_valid), 32'd0);
        check_output("reset frame_error", 32'(frame_error), 32'd0);
        check_output("reset miso", 32'(miso), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table pass at clk/sclk = 8, then again at the minimum ratio of 4
        prev_resp = '0;
        for (int pass = 0; pass < 2; pass++) begin
            hp = (pass == 0) ? 40 : 20;
            for (int k = 0; k < 6; k++) begin
                v0 = valid_cnt;
                e0 = err_cnt;
                apply_stimulus({vecs[k].op, vecs[k].a, vecs[k].b}, FB, 1'b1, rx);
                repeat (12) @(negedge clk);
                check_output($sformatf("p%0d v%0d opcode", pass, k), 32'(alu_opcode), 32'(vecs[k].op));
                check_output($sformatf("p%0d v%0d alu_a", pass, k), 32'(alu_a), 32'(vecs[k].a));
                check_output($sformatf("p%0d v%0d alu_b", pass, k), 32'(alu_b), 32'(vecs[k].b));
                check_output($sformatf("p%0d v%0d valid pulses", pass, k), 32'(valid_cnt - v0), 32'd1);
                check_output($sformatf("p%0d v%0d error pulses", pass, k), 32'(err_cnt - e0), 32'd0);
                check_output($sformatf("p%0d v%0d miso frame", pass, k), 32'(rx), 32'(prev_resp));
                prev_resp = vecs[k].resp;
            end
        end
        check_output("latency rise to valid", 32'(last_valid_t - last_rise_t <= 50 &&
                     last_valid_t > last_rise_t), 32'd1);

        // Short frame: error pulse, operands and pending response untouched
        keep_a  = alu_a;
        keep_b  = alu_b;
        keep_op = alu_opcode;
        v0 = valid_cnt;
        e0 = err_cnt;
        apply_stimulus(10'b11_1111_1111, 6, 1'b1, rx);
        repeat (12) @(negedge clk);
        check_output("abort error pulse", 32'(err_cnt - e0), 32'd1);
        check_output("abort valid pulses", 32'(valid_cnt - v0), 32'd0);
        check_output("abort alu_a held", 32'(alu_a), 32'(keep_a));
        check_output("abort alu_b held", 32'(alu_b), 32'(keep_b));
        check_output("abort opcode held", 32'(alu_opcode), 32'(keep_op));
        apply_stimulus(10'b11_0011_0100, FB, 1'b1, rx);
        repeat (12) @(negedge clk);
        check_output("post-abort miso frame", 32'(rx), 32'(prev_resp));
        prev_resp = 10'b0000_0111_00;

        // Reset landing in the middle of a frame
        v0 = valid_cnt;
        apply_stimulus(10'b01_0110_0001, 5, 1'b0, rx);
        rst = 1'b1;
        #1;
        check_output("midreset alu_a", 32'(alu_a), 32'd0);
        check_output("midreset alu_b", 32'(alu_b), 32'd0);
        check_output("midreset opcode", 32'(alu_opcode), 32'd0);
        check_output("midreset miso", 32'(miso), 32'd0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        e0 = err_cnt;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_output("midreset no error", 32'(err_cnt - e0), 32'd0);
        check_output("midreset no valid", 32'(valid_cnt - v0), 32'd0);
        apply_stimulus(10'b11_1010_0101, FB, 1'b1, rx);
        repeat (12) @(negedge clk);
        check_output("postreset opcode", 32'(alu_opcode), 32'd3);
        check_output("postreset alu_a", 32'(alu_a), 32'd10);
        check_output("postreset alu_b", 32'(alu_b), 32'd5);
        check_output("postreset miso frame", 32'(rx), 32'd0);
        prev_resp = 10'b0000_1111_00;

        // Back-to-back frames one sclk apart, second carries 12 extra bits
        v0 = valid_cnt;
        e0 = err_cnt;
        apply_stimulus(10'b00_0011_0101, FB, 1'b1, rx_a);
        #(2 * hp);
        apply_stimulus(10'b01_0001_0011, FB + 12, 1'b1, rx_b);
        repeat (12) @(negedge clk);
        check_output("b2b valid pulses", 32'(valid_cnt - v0), 32'd2);
        check_output("b2b error pulses", 32'(err_cnt - e0), 32'd0);
        check_output("b2b opcode", 32'(alu_opcode), 32'd1);
        check_output("b2b alu_a", 32'(alu_a), 32'd1);
        check_output("b2b alu_b", 32'(alu_b), 32'd3);
        check_output("b2b frame1 miso", 32'(rx_a), 32'(prev_resp));
        check_output("b2b frame2 miso", 32'(rx_b), 32'(10'b0000_1000_00));
        apply_stimulus(10'b10_1100_1010, FB, 1'b1, rx);
        repeat (12) @(negedge clk);
        check_output("b2b frame3 miso", 32'(rx), 32'(10'b1000_1110_00));
        check_output("b2b frame3 alu_a", 32'(alu_a), 32'(4'b1100));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
